// File: rtl/aes_const_pkg.sv
// Shared constants for the AES host sequencer: function encodings and default widths.
package aes_const;

  localparam int unsigned DATA_W      = 128;
  localparam int unsigned TAG_W       = 4;
  localparam int unsigned TIMEOUT_CYC = 64;
  localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] FUNC_IDLE    = 2'd0;
  localparam logic [1:0] FUNC_KEXP    = 2'd1;
  localparam logic [1:0] FUNC_CIPHER  = 2'd2;
  localparam logic [1:0] FUNC_ICIPHER = 2'd3;

endpackage

// File: rtl/aes_wire_pkg.sv
// Register bundle and reset value for the AES host sequencer.
package aes_wire;

  import aes_const::*;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  typedef struct packed {
    state_e              state;
    logic [1:0]          func;
    logic [DATA_W-1:0]   data;
    logic [DATA_W-1:0]   res;
    logic [TAG_W-1:0]    tag;
    logic                err;
    logic                key_valid;
    logic [CNT_W-1:0]    cnt;
  } aes_host_reg_type;

  localparam aes_host_reg_type init_aes_host_reg = '{
    state:     StIdle,
    func:      '0,
    data:      '0,
    res:       '0,
    tag:       '0,
    err:       1'b0,
    key_valid: 1'b0,
    cnt:       '0
  };

endpackage

// File: rtl/aes_host.sv
// Single-outstanding command sequencer in front of the AES core.
// Optional WAIT timeout is built when AES_TIMEOUT_EN is defined.
module aes_host
  import aes_wire::*;
#(
  parameter int unsigned DATA_W      = aes_const::DATA_W,
  parameter int unsigned TAG_W       = aes_const::TAG_W,
  parameter int unsigned TIMEOUT_CYC = aes_const::TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_func,
  input  logic [DATA_W-1:0] req_data,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              core_enable,
  output logic [1:0]        core_func,
  output logic [DATA_W-1:0] core_data,
  input  logic              core_ready,
  input  logic [DATA_W-1:0] core_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              key_valid,
  output logic              busy
);

`ifdef AES_TIMEOUT_EN
  localparam int unsigned   CntW       = aes_const::CNT_W;
  localparam logic [CntW-1:0] TimeoutVal = CntW'(TIMEOUT_CYC);
`endif

  aes_host_reg_type r_q, r_d;

  always_comb begin
    r_d = r_q;
    unique case (r_q.state)
      StIdle: begin
        if (req_valid) begin
          r_d.func = req_func;
          r_d.data = req_data;
          r_d.tag  = req_tag;
          r_d.res  = '0;
          // Idle func, or a cipher op with no expanded key, bypasses the core.
          if (req_func == aes_const::FUNC_IDLE || (req_func[1] && !r_q.key_valid)) begin
            r_d.err   = 1'b1;
            r_d.state = StResp;
          end else begin
            r_d.err   = 1'b0;
            r_d.state = StIssue;
          end
        end
      end
      StIssue: begin
        r_d.cnt   = '0;
        r_d.state = StWait;
        if (r_q.func == aes_const::FUNC_KEXP) r_d.key_valid = 1'b0;
      end
      StWait: begin
        if (core_ready) begin
          r_d.err   = 1'b0;
          r_d.state = StResp;
          if (r_q.func == aes_const::FUNC_KEXP) begin
            r_d.res       = '0;
            r_d.key_valid = 1'b1;
          end else begin
            r_d.res = core_result;
          end
        end
`ifdef AES_TIMEOUT_EN
        else begin
          r_d.cnt = r_q.cnt + 1'b1;
          if (r_d.cnt == TimeoutVal) begin
            r_d.err   = 1'b1;
            r_d.res   = '0;
            r_d.state = StResp;
          end
        end
`endif
      end
      StResp: begin
        if (rsp_ready) r_d.state = StIdle;
      end
      default: r_d = init_aes_host_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= init_aes_host_reg;
    end else begin
      r_q <= r_d;
    end
  end

  // req_ready is gated by rst so every output reads 0 while reset is held.
  assign req_ready   = (r_q.state == StIdle) && !rst;
  assign core_enable = (r_q.state == StIssue);
  assign core_func   = (r_q.state == StIssue) ? r_q.func : 2'b00;
  assign core_data   = r_q.data;
  assign rsp_valid   = (r_q.state == StResp);
  assign rsp_data    = r_q.res;
  assign rsp_tag     = r_q.tag;
  assign rsp_err     = r_q.err;
  assign key_valid   = r_q.key_valid;
  assign busy        = (r_q.state != StIdle);

endmodule

// File: tb/tb_aes_host.sv
// Directed self-checking bench for aes_host.
module tb_aes_host;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_func;
  logic [127:0] req_data;
  logic [3:0]   req_tag;
  logic         core_enable;
  logic [1:0]   core_func;
  logic [127:0] core_data;
  logic         core_ready;
  logic [127:0] core_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  logic [3:0]   rsp_tag;
  logic         rsp_err;
  logic         key_valid;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (core_enable) en_cnt++;

  aes_host #(
    .DATA_W(128),
    .TAG_W(4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_func(req_func),
    .req_data(req_data),
    .req_tag(req_tag),
    .core_enable(core_enable),
    .core_func(core_func),
    .core_data(core_data),
    .core_ready(core_ready),
    .core_result(core_result),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_tag(rsp_tag),
    .rsp_err(rsp_err),
    .key_valid(key_valid),
    .busy(busy)
  );

  // Presents one request for a single cycle; returns at the negedge after acceptance.
  task automatic send_req(input logic [1:0] f, input logic [127:0] d, input logic [3:0] t);
    @(negedge clk);
    req_valid = 1'b1;
    req_func  = f;
    req_data  = d;
    req_tag   = t;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for core_enable, captures the command, answers one cycle later.
  task automatic core_respond(input logic [127:0] res, output int seen,
                              output logic [1:0] f, output logic [127:0] d);
    seen = 0;
    f = 2'b00;
    d = '0;
    for (int i = 0; i < 20; i++) begin
      if (core_enable) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (seen == 1) begin
      f = core_func;
      d = core_data;
      @(negedge clk);
      core_ready  = 1'b1;
      core_result = res;
      @(negedge clk);
      core_ready  = 1'b0;
      core_result = JUNK;
    end
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0 || core_enable !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl got v=%b en=%b busy=%b exp 0", rsp_valid, core_enable, busy); end
    n_checks++; if (core_data !== '0 || rsp_data !== '0 || rsp_tag !== 4'd0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_data got cd=%h rd=%h tag=%h err=%b exp 0", core_data, rsp_data, rsp_tag, rsp_err); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset got rdy=%b kv=%b exp 1 0", req_ready, key_valid); end
  endtask

  task automatic test_reject_no_key();
    int en0;
    en0 = en_cnt;
    send_req(2'd2, PT, 4'd3);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      n_fail++; $display("FAIL nokey_rsp got v=%b err=%b exp 1 1", rsp_valid, rsp_err); end
    n_checks++; if (rsp_data !== '0 || rsp_tag !== 4'd3) begin
      n_fail++; $display("FAIL nokey_payload got d=%h tag=%h exp 0 3", rsp_data, rsp_tag); end
    rsp_handshake();
    n_checks++; if (en_cnt !== en0) begin n_fail++; $display("FAIL nokey_core_untouched got %0d exp %0d", en_cnt, en0); end
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL nokey_idle got v=%b busy=%b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_kexp();
    int en0, seen;
    logic [1:0] f;
    logic [127:0] d;
    en0 = en_cnt;
    send_req(2'd1, KEY, 4'd1);
    core_respond(JUNK, seen, f, d);
    n_checks++; if (seen !== 1 || f !== 2'd1 || d !== KEY) begin
      n_fail++; $display("FAIL kexp_cmd got seen=%0d f=%0d d=%h exp 1 1 %h", seen, f, d, KEY); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== '0 || rsp_tag !== 4'd1) begin
      n_fail++; $display("FAIL kexp_rsp got v=%b err=%b d=%h tag=%h exp 1 0 0 1", rsp_valid, rsp_err, rsp_data, rsp_tag); end
    n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL kexp_key_valid got %b exp 1", key_valid); end
    n_checks++; if (en_cnt - en0 !== 1) begin n_fail++; $display("FAIL kexp_enable_len got %0d exp 1", en_cnt - en0); end
    rsp_handshake();
  endtask

  task automatic test_cipher_backpressure();
    int seen;
    logic [1:0] f;
    logic [127:0] d;
    send_req(2'd2, PT, 4'd5);
    core_respond(CT, seen, f, d);
    n_checks++; if (seen !== 1 || f !== 2'd2 || d !== PT) begin
      n_fail++; $display("FAIL cipher_cmd got seen=%0d f=%0d d=%h exp 1 2 %h", seen, f, d, PT); end
    // A competing request is presented while the response is stalled; it must be ignored.
    req_valid = 1'b1; req_func = 2'd0; req_data = JUNK; req_tag = 4'd9;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== CT || rsp_tag !== 4'd5 || rsp_err !== 1'b0) begin
        n_fail++; $display("FAIL cipher_hold%0d got v=%b d=%h tag=%h err=%b exp 1 %h 5 0", i, rsp_valid, rsp_data, rsp_tag, rsp_err, CT); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL cipher_hold_rdy%0d got %b exp 0", i, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_handshake();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL cipher_after got busy=%b v=%b exp 0 0", busy, rsp_valid); end
  endtask

  task automatic test_icipher_stray();
    int seen;
    logic [1:0] f;
    logic [127:0] d;
    send_req(2'd3, CT, 4'd7);
    core_respond(PT, seen, f, d);
    n_checks++; if (seen !== 1 || f !== 2'd3 || d !== CT) begin
      n_fail++; $display("FAIL icipher_cmd got seen=%0d f=%0d d=%h exp 1 3 %h", seen, f, d, CT); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== PT || rsp_tag !== 4'd7 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL icipher_rsp got v=%b d=%h tag=%h err=%b exp 1 %h 7 0", rsp_valid, rsp_data, rsp_tag, rsp_err, PT); end
    rsp_handshake();
    core_ready = 1'b1; core_result = JUNK;
    @(negedge clk);
    core_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || key_valid !== 1'b1) begin
      n_fail++; $display("FAIL stray_ready got v=%b busy=%b kv=%b exp 0 0 1", rsp_valid, busy, key_valid); end
  endtask

  task automatic test_reset_mid_op();
    int en0;
    send_req(2'd2, PT, 4'd2);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL midop_wait got busy=%b v=%b exp 1 0", busy, rsp_valid); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b0 || core_enable !== 1'b0 || core_func !== 2'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midop_ctrl got rdy=%b en=%b f=%0d busy=%b exp 0", req_ready, core_enable, core_func, busy); end
    n_checks++; if (core_data !== '0 || rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_tag !== 4'd0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL midop_data got cd=%h v=%b rd=%h tag=%h err=%b exp 0", core_data, rsp_valid, rsp_data, rsp_tag, rsp_err); end
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL midop_key_valid got %b exp 0", key_valid); end
    rst = 1'b0;
    core_ready = 1'b1; core_result = CT;
    @(negedge clk);
    core_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midop_no_rsp got %b exp 0", rsp_valid); end
    en0 = en_cnt;
    send_req(2'd2, PT, 4'd4);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_tag !== 4'd4) begin
      n_fail++; $display("FAIL midop_reject got v=%b err=%b d=%h tag=%h exp 1 1 0 4", rsp_valid, rsp_err, rsp_data, rsp_tag); end
    rsp_handshake();
    n_checks++; if (en_cnt !== en0) begin n_fail++; $display("FAIL midop_core_untouched got %0d exp %0d", en_cnt, en0); end
  endtask

`ifdef AES_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    send_req(2'd1, KEY, 4'd6);
    n = -1;
    if (core_enable) begin
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (rsp_valid) begin
          n = i;
          break;
        end
      end
    end
    // Enable in cycle 1, eight WAIT cycles, response in the ninth cycle after enable.
    n_checks++; if (n !== 9) begin n_fail++; $display("FAIL timeout_latency got %0d exp 9", n); end
    n_checks++; if (rsp_err !== 1'b1 || rsp_data !== '0 || rsp_tag !== 4'd6 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_rsp got err=%b d=%h tag=%h kv=%b exp 1 0 6 0", rsp_err, rsp_data, rsp_tag, key_valid); end
    core_ready = 1'b1; core_result = JUNK;
    @(negedge clk);
    core_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_late_ready got v=%b err=%b kv=%b exp 1 1 0", rsp_valid, rsp_err, key_valid); end
    rsp_handshake();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle got busy=%b exp 0", busy); end
  endtask
`else
  task automatic test_wait_forever();
    send_req(2'd1, KEY, 4'd6);
    repeat (20) @(negedge clk);
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wait_persist got busy=%b v=%b exp 1 0", busy, rsp_valid); end
    core_ready = 1'b1; core_result = JUNK;
    @(negedge clk);
    core_ready = 1'b0;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== '0 || rsp_tag !== 4'd6 || key_valid !== 1'b1) begin
      n_fail++; $display("FAIL wait_late_rsp got v=%b err=%b d=%h tag=%h kv=%b exp 1 0 0 6 1", rsp_valid, rsp_err, rsp_data, rsp_tag, key_valid); end
    rsp_handshake();
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_func = 2'd0; req_data = '0; req_tag = '0;
    core_ready = 1'b0; core_result = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_reject_no_key();
    test_kexp();
    test_cipher_backpressure();
    test_icipher_stray();
    test_reset_mid_op();
`ifdef AES_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
